// File: rtl/toy_bus_pkg.sv
// Shared toy-bus definitions: default field widths, the beat payload layout
// and the route-table lookup used by decoder nodes.
package toy_bus_pkg;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_SB_W   = 32;
    localparam int DEF_ID_W   = 4;
    localparam int MAX_OUT    = 16;
    localparam int MAX_ID_W   = 16;

    typedef struct packed {
        logic                  opcode;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_SB_W-1:0]   sideband;
        logic [DEF_ID_W-1:0]   src_id;
        logic [DEF_ID_W-1:0]   tgt_id;
    } toy_bus_pay_t;

    // Table entries are zero-extended to MAX_ID_W; scanning downward lets
    // the lowest matching index overwrite any higher duplicate.
    function automatic logic [MAX_OUT-1:0] route_sel(
        input logic [MAX_OUT*MAX_ID_W-1:0] tbl,
        input logic [MAX_ID_W-1:0]         tgt,
        input int                          n_out
    );
        logic [MAX_OUT-1:0] sel;
        sel = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (i < n_out && tbl[i*MAX_ID_W +: MAX_ID_W] == tgt)
                sel = MAX_OUT'(1) << i;
        end
        return sel;
    endfunction

endpackage

// File: rtl/toy_bus_fwd_slice.sv
// One-entry full-throughput register slice carrying a payload plus a one-hot
// channel select; accepts a new beat in the same cycle the held one drains.
module toy_bus_fwd_slice #(
    parameter int PAY_W = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [PAY_W-1:0] in_pay,
    input  logic [SEL_W-1:0] in_sel,
    output logic [SEL_W-1:0] out_vld,
    input  logic [SEL_W-1:0] out_rdy,
    output logic [PAY_W-1:0] out_pay
);

    logic             vld_q, vld_d;
    logic [PAY_W-1:0] pay_q, pay_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             drain, load;

    // Only the ready of the channel holding the beat matters.
    assign drain   = vld_q & |(out_rdy & sel_q);
    assign in_rdy  = ~vld_q | drain;
    assign load    = in_vld & in_rdy;
    assign out_vld = {SEL_W{vld_q}} & sel_q;
    assign out_pay = pay_q;

    always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        sel_d = sel_q;
        if (load) begin
            vld_d = 1'b1;
            pay_d = in_pay;
            sel_d = in_sel;
        end else if (drain) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            pay_q <= '0;
            sel_q <= '0;
        end else begin
            vld_q <= vld_d;
            pay_q <= pay_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/toy_bus_ddec_node_reg.sv
// 1-to-N_OUT target-id decoder node: routes each beat to one channel by the
// RTE_IDS table, optionally through a register slice; unmapped beats are dropped.
module toy_bus_ddec_node_reg
    import toy_bus_pkg::*;
#(
    parameter int                    N_OUT     = 2,
    parameter int                    DATA_W    = DEF_DATA_W,
    parameter int                    SB_W      = DEF_SB_W,
    parameter int                    ID_W      = DEF_ID_W,
    parameter logic [N_OUT*ID_W-1:0] RTE_IDS   = {4'd1, 4'd0},
    parameter int                    FORWARD   = 1,
    parameter int                    ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in0_vld,
    output logic                 in0_rdy,
    input  logic                 in0_opcode,
    input  logic [DATA_W-1:0]    in0_data,
    input  logic [SB_W-1:0]      in0_sideband,
    input  logic [ID_W-1:0]      in0_src_id,
    input  logic [ID_W-1:0]      in0_tgt_id,
    output logic [N_OUT-1:0]     out_vld,
    input  logic [N_OUT-1:0]     out_rdy,
    output logic                 out_opcode,
    output logic [DATA_W-1:0]    out_data,
    output logic [SB_W-1:0]      out_sideband,
    output logic [ID_W-1:0]      out_src_id,
    output logic [ID_W-1:0]      out_tgt_id,
    output logic                 err_unmapped,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int PAY_W = 1 + DATA_W + SB_W + 2 * ID_W;

    logic [MAX_OUT*MAX_ID_W-1:0] rte_ext;
    logic [MAX_OUT-1:0]          sel_w;
    logic [N_OUT-1:0]            sel;
    logic                        mapped;
    logic [PAY_W-1:0]            in_pay, out_pay;

    always_comb begin
        rte_ext = '0;
        for (int i = 0; i < N_OUT; i++)
            rte_ext[i*MAX_ID_W +: MAX_ID_W] = MAX_ID_W'(RTE_IDS[i*ID_W +: ID_W]);
    end

    // route_sel never sets bits at or above N_OUT, so |sel_w equals |sel.
    assign sel_w  = route_sel(rte_ext, MAX_ID_W'(in0_tgt_id), N_OUT);
    assign sel    = sel_w[N_OUT-1:0];
    assign mapped = |sel_w;
    assign in_pay = {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};

    generate
        if (FORWARD != 0) begin : g_fwd
            toy_bus_fwd_slice #(
                .PAY_W (PAY_W),
                .SEL_W (N_OUT)
            ) u_slice (
                .clk     (clk),
                .rst     (rst),
                .in_vld  (in0_vld & mapped),
                .in_rdy  (in0_rdy),
                .in_pay  (in_pay),
                .in_sel  (sel),
                .out_vld (out_vld),
                .out_rdy (out_rdy),
                .out_pay (out_pay)
            );
        end else begin : g_comb
            assign out_vld = {N_OUT{in0_vld}} & sel;
            assign in0_rdy = |(out_rdy & sel) | ~mapped;
            assign out_pay = in_pay;
        end
    endgenerate

    assign {out_opcode, out_data, out_sideband, out_src_id, out_tgt_id} = out_pay;

    logic                 drop;
    logic                 err_unmapped_q, err_unmapped_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign drop = in0_vld & in0_rdy & ~mapped;

    // Clear wins over a drop landing in the same cycle.
    always_comb begin
        err_unmapped_d = err_unmapped_q;
        err_cnt_d      = err_cnt_q;
        if (err_clr) begin
            err_unmapped_d = 1'b0;
            err_cnt_d      = '0;
        end else if (drop) begin
            err_unmapped_d = 1'b1;
            if (err_cnt_q != '1)
                err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unmapped_q <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            err_unmapped_q <= err_unmapped_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign err_unmapped = err_unmapped_q;
    assign err_cnt      = err_cnt_q;

endmodule
